// File: rtl/l1_line_responder_if.sv
// l1_line_responder_if: bundles the L1 line-fill port (pmem_*) and the
// word-wide backing memory port (word_*) of the line responder.
// The responder uses the slave view; whoever drives requests and models
// memory uses the master view.
interface l1_line_responder_if;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic [15:0]  word_address;
    logic         word_read;
    logic [15:0]  word_rdata;
    logic         word_resp;

    modport slave (
        input  pmem_address, pmem_read, word_rdata, word_resp,
        output pmem_rdata, pmem_resp, word_address, word_read
    );

    modport master (
        output pmem_address, pmem_read, word_rdata, word_resp,
        input  pmem_rdata, pmem_resp, word_address, word_read
    );
endinterface

// File: rtl/l1_line_responder.sv
// l1_line_responder: fills a 128-bit L1 I-cache line by reading eight
// 16-bit words from a word-wide memory in ascending order, then returns the
// assembled line with a one-cycle pmem_resp.
// Optional macro L1_LINE_RESP_LASTLINE_EN: remember the last filled line
// base so a repeat request for that line is answered without refetching.
module l1_line_responder (
    input  logic                 clk,
    input  logic                 rst,
    l1_line_responder_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, FETCH, GAP, RESP} state_e;

    state_e        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [11:0]   base_q, base_d;          // line base without the 4 offset bits
    logic [15:0]   word_address_q, word_address_d;
    logic          word_read_q, word_read_d;
    logic          pmem_resp_q, pmem_resp_d;
    logic [127:0]  line_q, line_d;
    logic          hit;

`ifdef L1_LINE_RESP_LASTLINE_EN
    logic [11:0]   tag_q, tag_d;
    logic          valid_q, valid_d;
    assign hit = valid_q && (tag_q == bus.pmem_address[15:4]);
`else
    assign hit = 1'b0;
`endif

    // Next-state, counter, line assembly and registered output strobes.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        base_d         = base_q;
        line_d         = line_q;
`ifdef L1_LINE_RESP_LASTLINE_EN
        tag_d          = tag_q;
        valid_d        = valid_q;
`endif
        case (state_q)
            IDLE: begin
                // word_resp is deliberately ignored here: stray responses
                // must never land in the line.
                if (bus.pmem_read) begin
                    if (hit) begin
                        state_d = RESP;
                    end else begin
                        base_d  = bus.pmem_address[15:4];
                        cnt_d   = 3'd0;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (bus.word_resp) begin
                    line_d[{cnt_q, 4'b0000} +: 16] = bus.word_rdata;
                    if (cnt_q == 3'd7) begin
                        state_d = RESP;
`ifdef L1_LINE_RESP_LASTLINE_EN
                        tag_d   = base_q;
                        valid_d = 1'b1;
`endif
                    end else begin
                        cnt_d   = cnt_q + 3'd1;
                        state_d = GAP;
                    end
                end
            end
            GAP:     state_d = FETCH;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobes and address are registered from the next state so they
        // are clean and stable for the whole FETCH / RESP state.
        word_read_d    = (state_d == FETCH);
        pmem_resp_d    = (state_d == RESP);
        word_address_d = word_address_q;
        if (state_d == FETCH)
            word_address_d = {base_d, cnt_d, 1'b0};
    end

    // State and datapath registers; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= 3'd0;
            base_q         <= 12'd0;
            word_address_q <= 16'd0;
            word_read_q    <= 1'b0;
            pmem_resp_q    <= 1'b0;
            line_q         <= 128'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            base_q         <= base_d;
            word_address_q <= word_address_d;
            word_read_q    <= word_read_d;
            pmem_resp_q    <= pmem_resp_d;
            line_q         <= line_d;
        end
    end

`ifdef L1_LINE_RESP_LASTLINE_EN
    // Last-line tag and valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q   <= 12'd0;
            valid_q <= 1'b0;
        end else begin
            tag_q   <= tag_d;
            valid_q <= valid_d;
        end
    end
`endif

    assign bus.word_read    = word_read_q;
    assign bus.word_address = word_address_q;
    assign bus.pmem_resp    = pmem_resp_q;
    assign bus.pmem_rdata   = line_q;
endmodule

// File: doc/l1_line_responder.md
# l1_line_responder

Memory-side responder for the L1 instruction cache's line-fill interface. It accepts a line read request (`pmem_address`/`pmem_read`) from the L1, fetches the eight 16-bit words of that 128-bit line from a word-wide backing memory in ascending address order, assembles them into a `cache_line`, and returns the line with a single-cycle `pmem_resp`. It sits between the L1 I-cache and the word-wide physical memory port.

## Interface
- Parameters: none. Line width is fixed at 128 bits (`cache_line`, 8 words); word width is fixed at 16 bits (`lc3b_word`).
- `clk` in 1 — single clock; all logic is rising-edge.
- `rst` in 1 — synchronous, active-high reset.
- `pmem_address` in 16 — requested address; bits [3:0] are ignored, and line base = {pmem_address[15:4], 4'b0}.
- `pmem_read` in 1 — line read request; held high by the requester until `pmem_resp`.
- `pmem_rdata` out 128 — assembled line; word i occupies bits [16i+15:16i].
- `pmem_resp` out 1 — one-cycle pulse marking `pmem_rdata` valid.
- `word_address` out 16 — backing memory word address.
- `word_read` out 1 — backing memory read strobe.
- `word_rdata` in 16 — backing memory read data.
- `word_resp` in 1 — backing memory response; `word_rdata` is valid in the same cycle.

## Operation
- States: IDLE, FETCH, GAP, RESP.
- IDLE: `word_read`=0, `pmem_resp`=0. When `pmem_read`=1, latch the line base, clear the 3-bit counter `cnt`, and go to FETCH. `word_resp` is ignored in IDLE.
- FETCH: `word_read`=1, `word_address`=base + 2·cnt. Both are registered and stable for the whole state.
  - On `word_resp`, write `word_rdata` into slot `cnt`.
  - If `cnt`==7, go to RESP. Otherwise increment `cnt` and go to GAP.
- GAP: `word_read`=0 for exactly one cycle, then go to FETCH.
- RESP: `pmem_resp`=1 for exactly one cycle, then go to IDLE.
- `pmem_rdata` holds its value from RESP until the next fill overwrites slot 0.
- `cnt` wraps 7→0 only through the IDLE latch; slots are never written out of order.
- `pmem_read` is sampled only in IDLE. Address changes while busy are ignored.
- The requester deasserts `pmem_read` in the cycle after `pmem_resp`. If it is still high in IDLE, that is a new request.
- Reset at any point: state=IDLE, `cnt`=0, `word_read`=0, `pmem_resp`=0, `pmem_rdata`=0, `word_address`=0, last-line valid cleared. A `word_resp` arriving after reset is ignored. Reset takes priority over every transition.

## Timing
- Let cycle 0 be the edge at which IDLE samples `pmem_read`=1.
- Let L be the number of cycles from `word_read` assertion to `word_resp`, inclusive (L≥1).
- Each word costs L+1 cycles: FETCH plus GAP. The first `word_read` is in cycle 1.
- `pmem_resp` is asserted in cycle 8(L+1). For example, L=1 gives cycle 16 and L=3 gives cycle 32.
- The responder accepts one request at a time and keeps no queue.

## Configuration
- `L1_LINE_RESP_LASTLINE_EN`
  - Defined: keep a last-line tag (line base) and a valid bit. Valid is set and the tag is written on entry to RESP after a fill.
  - In IDLE, if `pmem_read`=1, valid=1, and the requested base equals the tag, go straight to RESP with no `word_read`. `pmem_resp` is asserted in cycle 1 and `pmem_rdata` is unchanged.
  - Not defined: no tag or valid storage; every request performs a full 8-word fetch.

## Test plan
- Reset, then request 0x1234; memory returns data = address with L=1.
  - `word_address` runs 0x1230, 0x1232, … 0x123E, with `word_read` low in each GAP cycle.
  - `pmem_rdata` = {0x123E, …, 0x1230}.
  - `pmem_resp` is a single pulse in cycle 16.
- Same request with L=3: `pmem_resp` in cycle 32; the data matches the previous case.
- Assert `rst` for one cycle during word 4 of a fill (`cnt`=4).
  - Next cycle: `word_read`=0, `pmem_resp` never pulses, `pmem_rdata`=0.
  - A following request to 0x4000 starts at `word_address` 0x4000.
- With `L1_LINE_RESP_LASTLINE_EN`: fill 0x1230, then request 0x1238.
  - `pmem_resp` in cycle 1, no `word_read`, same `pmem_rdata`.
  - A request to 0x2000 then performs a full fetch and replaces the tag.
  - Without the macro, the 0x1238 request refetches 8 words.
- Pulse `word_resp` with `word_rdata`=0xDEAD while IDLE, then fill 0x0000. The line contains no 0xDEAD and `cnt` starts at 0.
- Change `pmem_address` from 0x1230 to 0x5550 during FETCH. The fill completes for 0x1230 only.
